// File: rtl/mul4s_rr_arbiter.sv
// ============================================================================
// mul4s_rr_arbiter: round-robin sharing of one 4x4 signed multiplier | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mul4s_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] out
);
  logic signed [7:0] a_ext;
  logic signed [7:0] b_ext;

  // Sign-extending to 8 bits keeps -8*-8 = +64 representable.
  assign a_ext = {{4{a[3]}}, a};
  assign b_ext = {{4{b[3]}}, b};
  assign out   = a_ext * b_ext;
endmodule

module mul4s_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_prod,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);
  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_a_q, s1_a_d;
  logic [3:0]        s1_b_q, s1_b_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              res_valid_q, res_valid_d;
  logic [7:0]        res_prod_q, res_prod_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              s2_free, s1_adv, s1_free;
  logic              any_hi, any_lo, any_win, xfer;
  logic [ID_W-1:0]   hi_id, lo_id, win_id;
  logic [NUM_REQ-1:0] grant;
  logic [3:0]        sel_a, sel_b;
  logic [7:0]        core_out;

  assign s2_free = !res_valid_q || res_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign s1_free = !s1_valid_q || s1_adv;

  // Two passes: indices above the pointer first, then wrap to those at or below it.
  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_hi && req_valid[i] && (i > int'(ptr_q))) begin
        any_hi = 1'b1;
        hi_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_lo && req_valid[i] && (i <= int'(ptr_q))) begin
        any_lo = 1'b1;
        lo_id  = ID_W'(i);
      end
    end
    any_win = any_hi || any_lo;
    win_id  = any_hi ? hi_id : lo_id;
  end

  always_comb begin
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = any_win && (win_id == ID_W'(i));
      if (grant[i]) begin
        sel_a = req_a[i*4 +: 4];
        sel_b = req_b[i*4 +: 4];
      end
    end
  end

  // No grant is offered while reset is held, so nothing is accepted into a clearing pipe.
  assign req_ready = grant & {NUM_REQ{s1_free && rst_n}};
  assign xfer      = |(req_valid & req_ready);

  mul4s_core u_core (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .out (core_out)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_prod_d  = res_prod_q;
    res_id_d    = res_id_q;

    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = sel_a;
      s1_b_d     = sel_b;
      s1_id_d    = win_id;
      ptr_d      = win_id;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_prod_d  = core_out;
      res_id_d    = s1_id_q;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      res_valid_q <= 1'b0;
      res_prod_q  <= '0;
      res_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_prod_q  <= res_prod_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q || res_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_mul4s_rr_arbiter.sv
// Scoreboard bench for mul4s_rr_arbiter: random requesters and backpressure against a behavioural model.
`default_nettype none
`timescale 1ns/1ps

module tb_mul4s_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [7:0]           res_prod;
  logic [ID_W-1:0]      res_id;
  logic                 busy;

  always #5 clk = ~clk;

  mul4s_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .res_id    (res_id),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] prod;
    int         id;
    int         acc;
  } item_t;

  item_t              exp_q[$];
  logic [7:0]         pend[NUM_REQ][$];
  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  int                 ptr_m = NUM_REQ - 1;
  logic [NUM_REQ-1:0] grant_m = '0;
  bit                 end_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int sa;
    int sb;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    return 8'(sa * sb);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard: result channel against the queue, then the arbitration decision.
  always @(negedge clk or negedge rst_n) begin : mon
    int                 n;
    bit                 ev;
    int                 win;
    int                 c;
    logic [NUM_REQ-1:0] er;
    item_t              it;
    if (!rst_n) begin
      #1;
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      exp_q.delete();
      ptr_m   = NUM_REQ - 1;
      grant_m = '0;
    end else begin
      n  = exp_q.size();
      // A product is visible from the second edge after its acceptance onward.
      ev = (n > 0) && (exp_q[0].acc < cyc);
      chk("res_valid", int'(res_valid), int'(ev));
      chk("busy", int'(busy), int'(n > 0));
      if (res_valid && ev) begin
        chk("res_prod", int'(res_prod), int'(exp_q[0].prod));
        chk("res_id", int'(res_id), exp_q[0].id);
        if (res_ready) void'(exp_q.pop_front());
      end

      win = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (ptr_m + k) % NUM_REQ;
        if (win < 0 && req_valid[c]) win = c;
      end
      // Two in flight fill the pipe; a new accept then needs the output to drain this cycle.
      er = '0;
      if (win >= 0 && (n < 2 || res_ready)) er[win] = 1'b1;
      chk("req_ready", int'(req_ready), int'(er));
      grant_m = er;
      if (er != '0) begin
        it.prod = ref_mul(req_a[win*4 +: 4], req_b[win*4 +: 4]);
        it.id   = win;
        it.acc  = cyc + 1;
        exp_q.push_back(it);
        ptr_m = win;
      end
      if (end_chk) chk("drain_empty", exp_q.size(), 0);
    end
  end

  task automatic step(input int p_issue, input int p_rdy);
    logic [7:0] op;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~grant_m;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] && pend[i].size() > 0 && int'($urandom_range(0, 99)) < p_issue) begin
        op = pend[i].pop_front();
        req_a[i*4 +: 4] = op[7:4];
        req_b[i*4 +: 4] = op[3:0];
        req_valid[i]    = 1'b1;
      end
    end
    res_ready = (int'($urandom_range(0, 99)) < p_rdy);
  endtask

  task automatic run(input int cycles, input int p_issue, input int p_rdy);
    repeat (cycles) step(p_issue, p_rdy);
  endtask

  task automatic fill(input int per_req);
    for (int i = 0; i < NUM_REQ; i++)
      repeat (per_req) pend[i].push_back(8'($urandom));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // -8 * -8 from requester 0
    pend[0].push_back(8'h88);
    run(6, 100, 100);

    // -8 * 7, then 7 * -1 from requester 2
    pend[2].push_back(8'h87);
    pend[2].push_back(8'h7F);
    run(8, 100, 100);

    // all requesters streaming
    fill(10);
    run(24, 100, 100);

    // backpressure for five cycles in the middle of a stream
    fill(8);
    run(4, 100, 100);
    run(5, 100, 0);
    run(24, 100, 100);

    // requesters 1 and 3 contending under backpressure
    repeat (3) pend[1].push_back(8'($urandom));
    repeat (3) pend[3].push_back(8'($urandom));
    run(2, 100, 100);
    run(4, 100, 0);
    run(14, 100, 100);

    // reset with both stages full
    fill(6);
    run(3, 100, 100);
    run(3, 100, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pend[3].push_back(8'h88);
    pend[0].push_back(8'h87);
    run(8, 100, 100);

    // random traffic
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0)
        pend[$urandom_range(0, NUM_REQ-1)].push_back(8'($urandom));
      step(60, 70);
    end

    run(10, 0, 100);
    end_chk = 1'b1;
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
